alu_share_ctrl: RTL

Round-robin controller that shares one `simple_alu` instance between `NUM_REQ` requesters. It accepts one request at a time and latches that request's opcode and two operands. It serialises the command onto the ALU's `opcode_valid`/`opcode`/`data` pins, waits for `done`, and routes `result`/`overflow` back to the requester that was granted. It sits between the requester agents and the ALU in the `top` integration.

---
 rtl/alu_share_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 27 ++
 rtl/alu_share_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and helpers for the ALU sharing controller.
// Holds the controller state enum, default widths and the round-robin pick function.
package alu_share_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_OPC_W      = 2;
    localparam int DEF_TIMEOUT    = 64;

    // Widest supported requester set; the pick function works on this width
    // and callers zero-extend their request vector.
    localparam int MAX_REQ   = 8;
    localparam int MAX_PTR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // One-hot winner: first set bit of req at or after ptr, searching upward
    // and wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_PTR_W-1:0] ptr,
        input int                   n
    );
        logic [MAX_REQ-1:0]   win;
        logic                 found;
        logic [MAX_PTR_W-1:0] idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = MAX_PTR_W'((int'(ptr) + i) % n);
            if (!found && (i < n) && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner at or after rr_ptr.
module rr_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] win_ext;

    // Widen to the package helper's width and pick the winner.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        win_ext                = rr_pick(req_ext, MAX_PTR_W'(rr_ptr), NUM_REQ);
    end

    assign winner = win_ext[NUM_REQ-1:0];
    assign valid  = |win_ext;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one serial-opcode ALU between NUM_REQ requesters, round-robin.
// Optional WAIT timeout abort: define ALU_SHARE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; grant and latch the winner's opcode/operands
// SEND  | shift opcode MSB-first to the ALU, A on k=0, B on k=1
// WAIT  | wait for alu_done (or timeout when enabled)
// RESP  | one-cycle response pulse to the granted requester
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int OPC_W      = DEF_OPC_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*OPC_W-1:0]      req_opcode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_overflow,
    output logic                          rsp_error,
    output logic                          alu_opcode_valid,
    output logic                          alu_opcode,
    output logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          alu_done,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_overflow
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int K_W   = $clog2(OPC_W);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || OPC_W < 2 || TIMEOUT < 1) begin : g_param_check
        $error("alu_share_ctrl: parameter out of range");
    end

    state_t                  state;
    state_t                  state_n;
    logic [PTR_W-1:0]        rr_ptr;
    logic [K_W-1:0]          k_cnt;
    logic [NUM_REQ-1:0]      owner;
    logic [OPC_W-1:0]        op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    ovf_q;

    logic [NUM_REQ-1:0]      win;
    logic                    win_valid;
    logic [PTR_W-1:0]        win_idx;
    logic [OPC_W-1:0]        op_sel;
    logic [DATA_WIDTH-1:0]   a_sel;
    logic [DATA_WIDTH-1:0]   b_sel;

`ifdef ALU_SHARE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    err_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (win),
        .valid   (win_valid)
    );

    // Decode the winner index and mux out its opcode and operands.
    always_comb begin
        win_idx = '0;
        op_sel  = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx = PTR_W'(i);
                op_sel  = req_opcode[i*OPC_W +: OPC_W];
                a_sel   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_sel   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and outputs decoded from state.
    always_comb begin
        state_n          = state;
        gnt              = '0;
        rsp_valid        = '0;
        rsp_result       = '0;
        rsp_overflow     = 1'b0;
        rsp_error        = 1'b0;
        alu_opcode_valid = 1'b0;
        alu_opcode       = 1'b0;
        alu_data         = '0;
        case (state)
            IDLE: begin
                // Gated by reset_n so no grant leaks out while reset is held.
                if (win_valid && reset_n) begin
                    gnt     = win;
                    state_n = SEND;
                end
            end
            SEND: begin
                alu_opcode_valid = 1'b1;
                alu_opcode       = op_q[K_W'(OPC_W-1) - k_cnt];
                if (k_cnt == '0) begin
                    alu_data = a_q;
                end else if (k_cnt == K_W'(1)) begin
                    alu_data = b_q;
                end
                if (k_cnt == K_W'(OPC_W-1)) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (alu_done) begin
                    state_n = RESP;
                end
`ifdef ALU_SHARE_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    state_n = RESP;
                end
`endif
            end
            RESP: begin
                rsp_valid    = owner;
                rsp_result   = res_q;
                rsp_overflow = ovf_q;
`ifdef ALU_SHARE_TIMEOUT_EN
                rsp_error    = err_q;
`endif
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, round-robin pointer, serialiser index and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr  <= '0;
            k_cnt   <= '0;
            owner   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef ALU_SHARE_TIMEOUT_EN
            tmo_cnt <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        owner  <= win;
                        op_q   <= op_sel;
                        a_q    <= a_sel;
                        b_q    <= b_sel;
                        k_cnt  <= '0;
                        rr_ptr <= (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                    end
                end
                SEND: begin
                    k_cnt   <= k_cnt + 1'b1;
`ifdef ALU_SHARE_TIMEOUT_EN
                    // Down-counter loaded so terminal count hits on the last allowed WAIT cycle.
                    tmo_cnt <= TMO_W'(TIMEOUT - 1);
`endif
                end
                WAIT: begin
                    if (alu_done) begin
                        res_q <= alu_result;
                        ovf_q <= alu_overflow;
`ifdef ALU_SHARE_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
`ifdef ALU_SHARE_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        res_q <= '0;
                        ovf_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
